mem_request_arbiter: RTL and testbench

Parametrised successor to the single-port CPU request unit: arbitrates instruction fetch and data load/store onto one wishbone-style bus master port, with byte/halfword/word lane selection, load sign/zero extension and misalignment detection. Sits between the core pipeline (IF and MEM stages) and the wishbone bus manager. It provides one-cycle `i_ready`/`d_ready` completion pulses that gate PC advance and MEM-stage stall release.

---
 rtl/mem_request_arbiter_pkg.sv | 39 +++
 rtl/mem_request_arbiter_lanes.sv | 74 +++++++
 rtl/mem_request_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_request_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_request_arbiter_pkg.sv
// mem_req_pkg: shared types and helpers for the memory request arbiter.
//   mreq_state_t : arbiter FSM states (IDLE, STROBE, WAIT, RESP)
//   mem_size_t   : access size encoding (BYTE, HALF, WORD; 3 is illegal)
//   mreq_req_t   : requester tag (REQ_I fetch, REQ_D data)
//   extend_load  : sign/zero extension of an extracted byte or halfword
package mem_req_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } mreq_state_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } mreq_req_t;

  // Extend a right-aligned byte (v[7:0]) or halfword (v[15:0]) to 32 bits.
  function automatic logic [31:0] extend_load(input logic [15:0] v,
                                              input logic        is_half,
                                              input logic        uns);
    logic sign_s;
    sign_s = uns ? 1'b0 : (is_half ? v[15] : v[7]);
    if (is_half) begin
      extend_load = {{16{sign_s}}, v};
    end else begin
      extend_load = {{24{sign_s}}, v[7:0]};
    end
  endfunction

endpackage

// File: rtl/mem_request_arbiter_lanes.sv
// byte_lane_unit: combinational byte-lane logic for the request arbiter.
//   Request side (live request): byte enables, lane-replicated store data and
//   the misaligned/illegal flag.
//   Load side (latched request): byte/half extraction from bus read data and
//   sign/zero extension.
// Ports:
//   req_lo_i, req_size_i, req_wdata_i -> sel_o, wdata_o, bad_o
//   ld_lo_i, ld_size_i, ld_unsigned_i, ld_data_i -> ld_rdata_o
module byte_lane_unit
  import mem_req_pkg::*;
(
  input  logic [1:0]  req_lo_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic        bad_o,
  input  logic [1:0]  ld_lo_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] ld_rdata_o
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Request side: lane mask, replicated write data, alignment check.
  always_comb begin
    sel_o   = 4'b0000;
    wdata_o = 32'h0000_0000;
    bad_o   = 1'b1;
    case (req_size_i)
      BYTE: begin
        sel_o   = 4'b0001 << req_lo_i;
        wdata_o = {4{req_wdata_i[7:0]}};
        bad_o   = 1'b0;
      end
      HALF: begin
        sel_o   = req_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{req_wdata_i[15:0]}};
        bad_o   = req_lo_i[0];
      end
      WORD: begin
        sel_o   = 4'b1111;
        wdata_o = req_wdata_i;
        bad_o   = (req_lo_i != 2'b00);
      end
      default: begin
        sel_o   = 4'b0000;
        wdata_o = 32'h0000_0000;
        bad_o   = 1'b1;
      end
    endcase
  end

  // Load side: pick the addressed lane and extend it.
  always_comb begin
    case (ld_lo_i)
      2'd0:    ld_byte_s = ld_data_i[7:0];
      2'd1:    ld_byte_s = ld_data_i[15:8];
      2'd2:    ld_byte_s = ld_data_i[23:16];
      2'd3:    ld_byte_s = ld_data_i[31:24];
      default: ld_byte_s = 8'h00;
    endcase
    ld_half_s = ld_lo_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    case (ld_size_i)
      BYTE:    ld_rdata_o = extend_load({8'h00, ld_byte_s}, 1'b0, ld_unsigned_i);
      HALF:    ld_rdata_o = extend_load(ld_half_s, 1'b1, ld_unsigned_i);
      default: ld_rdata_o = ld_data_i;
    endcase
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: arbitrates instruction fetch and data load/store onto a
// single wishbone-style bus master port. Data requests win over fetches.
// Optional feature macro: MEM_REQ_TIMEOUT_EN (abort a WAIT after
// TIMEOUT_CYCLES consecutive busy cycles with err=1).
// Ports:
//   clk, rst (async active-low)
//   CPU fetch : i_req, i_addr -> i_ready, i_data
//   CPU data  : d_read, d_write, d_addr, d_wdata, d_size, d_unsigned
//               -> d_ready, d_rdata, err
//   Bus       : read_i, write_i, adr_i, cpu_dat_i, sel_i <- busy_o, cpu_dat_o
module mem_request_arbiter
  import mem_req_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_data,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              err,
  output logic              read_i,
  output logic              write_i,
  output logic [ADDR_W-1:0] adr_i,
  output logic [31:0]       cpu_dat_i,
  output logic [3:0]        sel_i,
  input  logic              busy_o,
  input  logic [31:0]       cpu_dat_o
);

  mreq_state_t state_q, state_d;
  mreq_req_t   req_q, req_d;
  logic [1:0]  size_q, size_d, lo_q, lo_d;
  logic        uns_q, uns_d, store_q, store_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d, i_data_q, i_data_d, d_rdata_q, d_rdata_d;
  logic        read_q, read_d, write_q, write_d;
  logic        i_ready_q, i_ready_d, d_ready_q, d_ready_d, err_q, err_d;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Live request view, used only while IDLE.
  logic              d_pend_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic [1:0]        req_size_s;
  logic [3:0]        sel_s;
  logic [31:0]       wdata_al_s, ld_rdata_s;
  logic              bad_s;

  assign d_pend_s   = d_read | d_write;
  assign req_addr_s = d_pend_s ? d_addr : i_addr;
  // Fetches are always word accesses, so they share the word alignment check.
  assign req_size_s = d_pend_s ? d_size : WORD;

  byte_lane_unit u_lanes (
    .req_lo_i      (req_addr_s[1:0]),
    .req_size_i    (req_size_s),
    .req_wdata_i   (d_wdata),
    .sel_o         (sel_s),
    .wdata_o       (wdata_al_s),
    .bad_o         (bad_s),
    .ld_lo_i       (lo_q),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_data_i     (cpu_dat_o),
    .ld_rdata_o    (ld_rdata_s)
  );

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    size_d    = size_q;
    lo_d      = lo_q;
    uns_d     = uns_q;
    store_d   = store_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    read_d    = 1'b0;
    write_d   = 1'b0;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    err_d     = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_pend_s || i_req) begin
          req_d   = d_pend_s ? REQ_D : REQ_I;
          store_d = d_pend_s & d_write;
          size_d  = req_size_s;
          lo_d    = req_addr_s[1:0];
          uns_d   = d_unsigned;
          adr_d   = {req_addr_s[ADDR_W-1:2], 2'b00};
          sel_d   = sel_s;
          dat_d   = d_pend_s ? wdata_al_s : 32'h0000_0000;
          if (bad_s) begin
            // Bad accesses never touch the bus.
            state_d   = RESP;
            err_d     = 1'b1;
            i_ready_d = ~d_pend_s;
            d_ready_d = d_pend_s;
          end else begin
            state_d = STROBE;
            write_d = d_pend_s & d_write;
            read_d  = ~(d_pend_s & d_write);
          end
        end else begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        state_d = WAIT;
`ifdef MEM_REQ_TIMEOUT_EN
        cnt_d   = {CNT_W{1'b0}};
`endif
      end
      WAIT: begin
        if (!busy_o) begin
          state_d   = RESP;
          i_ready_d = (req_q == REQ_I);
          d_ready_d = (req_q == REQ_D);
          if (req_q == REQ_I) begin
            i_data_d = cpu_dat_o;
          end else if (!store_q) begin
            d_rdata_d = ld_rdata_s;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else begin
`ifdef MEM_REQ_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = RESP;
            err_d     = 1'b1;
            i_ready_d = (req_q == REQ_I);
            d_ready_d = (req_q == REQ_D);
          end else begin
            state_d = WAIT;
            cnt_d   = cnt_q + CNT_W'(1);
          end
`else
          state_d = WAIT;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_q     <= REQ_I;
      size_q    <= WORD;
      lo_q      <= 2'b00;
      uns_q     <= 1'b0;
      store_q   <= 1'b0;
      adr_q     <= {ADDR_W{1'b0}};
      sel_q     <= 4'b0000;
      dat_q     <= 32'h0000_0000;
      i_data_q  <= 32'h0000_0000;
      d_rdata_q <= 32'h0000_0000;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
      cnt_q     <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      size_q    <= size_d;
      lo_q      <= lo_d;
      uns_q     <= uns_d;
      store_q   <= store_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      err_q     <= err_d;
`ifdef MEM_REQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign i_ready   = i_ready_q;
  assign i_data    = i_data_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign read_i    = read_q;
  assign write_i   = write_q;
  assign adr_i     = adr_q;
  assign cpu_dat_i = dat_q;
  assign sel_i     = sel_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
module tb_mem_request_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_read, d_write, d_unsigned, busy_o;
  logic [31:0] i_addr, d_addr, d_wdata, cpu_dat_o;
  logic [1:0]  d_size;
  logic        i_ready, d_ready, err, read_i, write_i;
  logic [31:0] i_data, d_rdata, adr_i, cpu_dat_i;
  logic [3:0]  sel_i;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_i, exp_d;

  always #5 clk = ~clk;

  mem_request_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_unsigned(d_unsigned), .d_ready(d_ready), .d_rdata(d_rdata),
    .err(err), .read_i(read_i), .write_i(write_i), .adr_i(adr_i),
    .cpu_dat_i(cpu_dat_i), .sel_i(sel_i), .busy_o(busy_o), .cpu_dat_o(cpu_dat_o)
  );

  typedef struct {
    bit          fetch;
    bit          store;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] wdata;
    logic [31:0] bus;
    int          nbusy;
    bit          bstrobe;
    bit          e_err;
    logic [3:0]  e_sel;
    logic [31:0] e_adr;
    logic [31:0] e_dat;
    logic [31:0] e_data;
    int          e_lat;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ".i_ready"}, {31'd0, i_ready}, 32'd0);
    check({nm, ".d_ready"}, {31'd0, d_ready}, 32'd0);
    check({nm, ".err"}, {31'd0, err}, 32'd0);
    check({nm, ".read_i"}, {31'd0, read_i}, 32'd0);
    check({nm, ".write_i"}, {31'd0, write_i}, 32'd0);
    check({nm, ".adr_i"}, adr_i, 32'd0);
    check({nm, ".cpu_dat_i"}, cpu_dat_i, 32'd0);
    check({nm, ".sel_i"}, {28'd0, sel_i}, 32'd0);
    check({nm, ".i_data"}, i_data, 32'd0);
    check({nm, ".d_rdata"}, d_rdata, 32'd0);
  endtask

  // Reference: expected result of one access from the address/size rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int lo, nb;
    bit bad, tmo;
    logic [31:0] mask, raw;
    r  = v;
    lo = int'(v.addr[1:0]);
    nb = v.fetch ? 4 : (v.size == 2'd0 ? 1 : v.size == 2'd1 ? 2 : v.size == 2'd2 ? 4 : 0);
    bad = v.fetch ? (lo != 0) : (nb == 0 || (lo % nb) != 0);
`ifdef MEM_REQ_TIMEOUT_EN
    tmo = (v.nbusy >= TO);
`else
    tmo = 1'b0;
`endif
    r.e_adr = v.addr & ~32'h3;
    r.e_sel = 4'b0000;
    r.e_dat = 32'h0;
    r.e_data = 32'h0;
    if (nb > 0) begin
      r.e_sel = 4'(((1 << nb) - 1) << lo);
      for (int k = 0; k < 4; k++) r.e_dat[8*k +: 8] = v.wdata[8*(k % nb) +: 8];
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
      raw  = (v.bus >> (8 * lo)) & mask;
      if (!v.fetch && !v.uns && nb < 4 && raw[8*nb-1]) raw = raw | ~mask;
      r.e_data = v.fetch ? v.bus : raw;
    end
    r.e_err = bad || tmo;
    r.e_lat = bad ? 1 : (tmo ? 2 + TO : 3 + v.nbusy);
    return r;
  endfunction

  // Apply one access, hold it until ready, then drop it and check everything.
  task automatic run_txn(input vec_t v, input string nm);
    int s_cnt, s_cyc, r_cyc, extra;
    logic s_rd, s_wr, r_i, r_d, r_err;
    logic [31:0] s_adr, s_dat;
    logic [3:0] s_sel;
    s_cnt = 0; s_cyc = -1; r_cyc = -1; extra = 0;
    s_rd = 1'b0; s_wr = 1'b0; r_i = 1'b0; r_d = 1'b0; r_err = 1'b0;
    s_adr = 32'h0; s_dat = 32'h0; s_sel = 4'h0;
    i_req = v.fetch; i_addr = v.addr;
    d_read = !v.fetch && !v.store; d_write = !v.fetch && v.store;
    d_addr = v.addr; d_size = v.size; d_unsigned = v.uns; d_wdata = v.wdata;
    cpu_dat_o = v.bus;
    for (int c = 0; c < 40 && r_cyc < 0; c++) begin
      busy_o = (c == 1) ? v.bstrobe : (c >= 2 && c < 2 + v.nbusy);
      @(negedge clk);
      if (read_i || write_i) begin
        s_cnt++; s_cyc = c; s_rd = read_i; s_wr = write_i;
        s_adr = adr_i; s_sel = sel_i; s_dat = cpu_dat_i;
      end
      if (i_ready || d_ready) begin
        r_cyc = c; r_i = i_ready; r_d = d_ready; r_err = err;
      end
      @(posedge clk); #1;
    end
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0; busy_o = 1'b0;
    if (!v.e_err && v.fetch) exp_i = v.e_data;
    if (!v.e_err && !v.fetch && !v.store) exp_d = v.e_data;
    check({nm, ".ready_cycle"}, r_cyc, v.e_lat);
    check({nm, ".err"}, {31'd0, r_err}, {31'd0, v.e_err});
    check({nm, ".which_ready"}, {30'd0, r_i, r_d}, v.fetch ? 32'd2 : 32'd1);
    check({nm, ".strobes"}, s_cnt, (v.e_lat == 1) ? 32'd0 : 32'd1);
    if (v.e_lat != 1) begin
      check({nm, ".strobe_cycle"}, s_cyc, 32'd1);
      check({nm, ".strobe_kind"}, {30'd0, s_rd, s_wr}, v.store ? 32'd1 : 32'd2);
      check({nm, ".adr_i"}, s_adr, v.e_adr);
      check({nm, ".sel_i"}, {28'd0, s_sel}, {28'd0, v.e_sel});
      if (v.store) check({nm, ".cpu_dat_i"}, s_dat, v.e_dat);
    end
    check({nm, ".i_data"}, i_data, exp_i);
    check({nm, ".d_rdata"}, d_rdata, exp_d);
    @(negedge clk);
    if (i_ready || d_ready || read_i || write_i) extra++;
    check({nm, ".no_repeat"}, extra, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int ni, nd, i_cyc, d_cyc, got;
    logic [31:0] sq[$];
    vec_t v;
    rst = 1'b0; i_req = 1'b0; d_read = 1'b0; d_write = 1'b0; d_unsigned = 1'b0;
    busy_o = 1'b0; i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    cpu_dat_o = 32'h0; d_size = 2'd0; exp_i = 32'h0; exp_d = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // fetch store addr size uns wdata bus nbusy bstrobe | err sel adr dat data lat
    tbl[0]  = '{1, 0, 32'h100, 2'd2, 0, 32'h0, 32'h0050_0093, 2, 0, 0, 4'hF, 32'h100, 32'h0, 32'h0050_0093, 5};
    tbl[1]  = '{0, 1, 32'h203, 2'd0, 0, 32'hAB, 32'h0, 0, 0, 0, 4'h8, 32'h200, 32'hABAB_ABAB, 32'h0, 3};
    tbl[2]  = '{0, 0, 32'h12, 2'd1, 0, 32'h0, 32'h8001_0000, 0, 0, 0, 4'hC, 32'h10, 32'h0, 32'hFFFF_8001, 3};
    tbl[3]  = '{0, 0, 32'h12, 2'd1, 1, 32'h0, 32'h8001_0000, 0, 0, 0, 4'hC, 32'h10, 32'h0, 32'h0000_8001, 3};
    tbl[4]  = '{0, 0, 32'h6, 2'd2, 0, 32'h0, 32'hFFFF_FFFF, 0, 0, 1, 4'h0, 32'h0, 32'h0, 32'h0, 1};
    tbl[5]  = '{0, 0, 32'h40, 2'd3, 0, 32'h0, 32'hFFFF_FFFF, 0, 0, 1, 4'h0, 32'h0, 32'h0, 32'h0, 1};
    tbl[6]  = '{1, 0, 32'h102, 2'd2, 0, 32'h0, 32'h1234_5678, 0, 0, 1, 4'h0, 32'h0, 32'h0, 32'h0, 1};
    tbl[7]  = '{0, 1, 32'h301, 2'd1, 0, 32'h5555, 32'h0, 0, 0, 1, 4'h0, 32'h0, 32'h0, 32'h0, 1};
    tbl[8]  = '{0, 0, 32'h41, 2'd0, 0, 32'h0, 32'h0000_8000, 0, 1, 0, 4'h2, 32'h40, 32'h0, 32'hFFFF_FF80, 3};
    tbl[9]  = '{0, 1, 32'h22, 2'd1, 0, 32'h1234_BEEF, 32'h0, 0, 0, 0, 4'hC, 32'h20, 32'hBEEF_BEEF, 32'h0, 3};
    tbl[10] = '{0, 1, 32'h30, 2'd2, 0, 32'hDEAD_BEEF, 32'h0, 1, 1, 0, 4'hF, 32'h30, 32'hDEAD_BEEF, 32'h0, 4};
    tbl[11] = '{0, 0, 32'h44, 2'd2, 0, 32'h0, 32'hCAFE_F00D, 3, 0, 0, 4'hF, 32'h44, 32'h0, 32'hCAFE_F00D, 6};
    foreach (tbl[k]) run_txn(tbl[k], $sformatf("vec%0d", k));

    // Simultaneous fetch and load: data first, fetch after an IDLE cycle.
    ni = 0; nd = 0; i_cyc = -1; d_cyc = -1;
    i_req = 1'b1; i_addr = 32'h400; d_read = 1'b1; d_write = 1'b0;
    d_addr = 32'h88; d_size = 2'd2; d_unsigned = 1'b0; cpu_dat_o = 32'h1122_3344; busy_o = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (read_i || write_i) sq.push_back(adr_i);
      if (d_ready) begin nd++; d_cyc = c; end
      if (i_ready) begin ni++; i_cyc = c; end
      @(posedge clk); #1;
      if (nd > 0) begin d_read = 1'b0; cpu_dat_o = 32'h00A0_0113; end
      if (ni > 0) i_req = 1'b0;
    end
    exp_d = 32'h1122_3344; exp_i = 32'h00A0_0113;
    check("conflict.d_count", nd, 32'd1);
    check("conflict.i_count", ni, 32'd1);
    check("conflict.d_cycle", d_cyc, 32'd3);
    check("conflict.i_cycle", i_cyc, 32'd7);
    check("conflict.strobes", sq.size(), 32'd2);
    if (sq.size() == 2) begin
      check("conflict.first_adr", sq[0], 32'h88);
      check("conflict.second_adr", sq[1], 32'h400);
    end
    check("conflict.d_rdata", d_rdata, exp_d);
    check("conflict.i_data", i_data, exp_i);

    // Reset in the middle of a WAIT.
    d_read = 1'b1; d_addr = 32'h50; d_size = 2'd2; busy_o = 1'b1; cpu_dat_o = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    got = 0;
    repeat (3) begin
      @(negedge clk);
      if (i_ready || d_ready) got++;
    end
    check("rst_mid.no_ready", got, 32'd0);
    @(posedge clk); #1;
    d_read = 1'b0; busy_o = 1'b0; rst = 1'b1;
    exp_i = 32'h0; exp_d = 32'h0;

`ifdef MEM_REQ_TIMEOUT_EN
    // Load first so d_rdata holds a known value, then time out.
    run_txn(tbl[11], "pre_timeout");
    v = '{0, 0, 32'h60, 2'd2, 0, 32'h0, 32'h7777_7777, 50, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0};
    v = model(v);
    run_txn(v, "timeout");
`endif

    for (int n = 0; n < 120; n++) begin
      v.fetch = ($urandom_range(0, 3) == 0);
      v.store = !v.fetch && ($urandom_range(0, 1) == 1);
      v.addr  = 32'($urandom_range(0, 4095));
      if (v.fetch && $urandom_range(0, 3) != 0) v.addr = v.addr & ~32'h3;
      v.size  = 2'($urandom_range(0, 3));
      v.uns   = ($urandom_range(0, 1) == 1);
      v.wdata = $urandom;
      v.bus   = $urandom;
      v.nbusy = $urandom_range(0, 3);
      v.bstrobe = ($urandom_range(0, 1) == 1);
      v = model(v);
      run_txn(v, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
